instruction_fetch_unit: RTL and testbench

Initiator side of the instruction-memory interface. It owns the program counter (PC), drives Address to the combinational instruction ROM, and samples the returned Word into an IF/ID register for the decode stage. It also handles stall, branch redirect, and in-fetch J-type redirect. It detects a self-loop halt and a ROM-default fault.

---
 rtl/instruction_fetch_unit_if.sv | 9 +
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the
// combinational instruction ROM (slave).
interface instruction_fetch_unit_if;
  logic [31:0] Address;
  logic [31:0] Word;

  modport master (output Address, input Word);
  modport slave  (input Address, output Word);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the ROM address, and registers
// the returned word into the IF/ID stage. Handles stall, branch redirect,
// in-fetch J redirect, self-loop halt detection and ROM-default fault.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] FAULT_WORD = 32'hFFFF_FFFF
) (
  input  logic                              clk,
  input  logic                              rst,
  instruction_fetch_unit_if.master          imem,
  input  logic                              Stall,
  input  logic                              BranchTaken,
  input  logic [31:0]                       BranchTarget,
  output logic [31:0]                       Instr,
  output logic [31:0]                       InstrPC,
  output logic                              InstrValid,
  output logic                              Halted,
  output logic                              Fault,
  output logic [31:0]                       FetchCount
);

  localparam logic [5:0] OP_J = 6'b000010;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] j_target;
  logic        is_j;

  logic [31:0] pc_n;
  logic [31:0] instr_n;
  logic [31:0] instr_pc_n;
  logic        valid_n;
  logic        halted_n;
  logic        fault_n;
  logic [31:0] count_n;

  // ROM has zero-cycle latency, so the address is the PC register itself.
  assign imem.Address = pc;

  assign pc_plus4 = pc + 32'd4;
  assign is_j     = (imem.Word[31:26] == OP_J);
  assign j_target = {pc_plus4[31:28], imem.Word[25:0], 2'b00};

  // Next-state selection with priority: branch > stall > halted/fault > fetch.
  always_comb begin
    pc_n       = pc;
    instr_n    = Instr;
    instr_pc_n = InstrPC;
    valid_n    = InstrValid;
    halted_n   = Halted;
    fault_n    = Fault;
    count_n    = FetchCount;

    if (BranchTaken) begin
      if (BranchTarget[1:0] != 2'b00) begin
        fault_n = 1'b1;
      end else begin
        pc_n = BranchTarget;
      end
      valid_n = 1'b0;
    end else if (Stall) begin
      // hold everything
    end else if (Halted || Fault) begin
      valid_n = 1'b0;
    end else if (imem.Word == FAULT_WORD) begin
      fault_n = 1'b1;
      valid_n = 1'b0;
    end else begin
      instr_n    = imem.Word;
      instr_pc_n = pc;
      valid_n    = 1'b1;
      count_n    = FetchCount + 32'd1;
      if (is_j) begin
        // A jump to itself is delivered once, then fetch parks on that PC.
        if (j_target == pc) begin
          halted_n = 1'b1;
        end else begin
          pc_n = j_target;
        end
      end else begin
        pc_n = pc_plus4;
      end
    end
  end

  // State register with synchronous reset overriding every other condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      Instr      <= '0;
      InstrPC    <= '0;
      InstrValid <= 1'b0;
      Halted     <= 1'b0;
      Fault      <= 1'b0;
      FetchCount <= '0;
    end else begin
      pc         <= pc_n;
      Instr      <= instr_n;
      InstrPC    <= instr_pc_n;
      InstrValid <= valid_n;
      Halted     <= halted_n;
      Fault      <= fault_n;
      FetchCount <= count_n;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by randomized stall/branch/reset traffic against a behavioural model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] FAULT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_W   = 32'h0000_0020;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        Halted;
  logic        Fault;
  logic [31:0] FetchCount;

  logic [31:0] mem [0:255];

  int unsigned checks;
  int unsigned failures;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_valid;
  logic        m_halted;
  logic        m_fault;
  logic [31:0] m_count;

  instruction_fetch_unit_if imem ();

  // ROM: 1 KiB mapped at 0, one NOP at the top word, FAULT_W elsewhere.
  assign imem.Word = (imem.Address == 32'hFFFF_FFFC) ? NOP_W :
                     (imem.Address < 32'h0000_0400)  ? mem[imem.Address[9:2]] :
                                                       FAULT_W;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FAULT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .InstrValid   (InstrValid),
    .Halted       (Halted),
    .Fault        (Fault),
    .FetchCount   (FetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'hFFFF_FFFC) return NOP_W;
    if (a < 32'h0000_0400)  return mem[a / 4];
    return FAULT_W;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_edge(input logic r, input logic st, input logic br,
                            input logic [31:0] tgt);
    logic [31:0] w;
    logic [31:0] dest;
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_valid = 1'b0;
      m_halted = 1'b0; m_fault = 1'b0; m_count = 32'h0;
    end else if (br) begin
      if (tgt % 4 != 0) m_fault = 1'b1;
      else              m_pc = tgt;
      m_valid = 1'b0;
    end else if (st) begin
      // nothing moves
    end else if (m_halted || m_fault) begin
      m_valid = 1'b0;
    end else begin
      w = rom(m_pc);
      if (w == FAULT_W) begin
        m_fault = 1'b1;
        m_valid = 1'b0;
      end else begin
        m_instr = w;
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_count = m_count + 1;
        if ((w >> 26) == 32'd2) begin
          dest = ((m_pc + 4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
          if (dest == m_pc) m_halted = 1'b1;
          else              m_pc = dest;
        end else begin
          m_pc = m_pc + 4;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("Address",    imem.Address, m_pc);
    check("Instr",      Instr,        m_instr);
    check("InstrPC",    InstrPC,      m_ipc);
    check("InstrValid", {31'b0, InstrValid}, {31'b0, m_valid});
    check("Halted",     {31'b0, Halted},     {31'b0, m_halted});
    check("Fault",      {31'b0, Fault},      {31'b0, m_fault});
    check("FetchCount", FetchCount,   m_count);
  endtask

  // Drive inputs away from the edge, clock once, then compare after the edge.
  task automatic cycle(input logic r, input logic st, input logic br,
                       input logic [31:0] tgt);
    @(negedge clk);
    rst = r; Stall = st; BranchTaken = br; BranchTarget = tgt;
    @(posedge clk);
    model_edge(r, st, br, tgt);
    #1;
    compare_all();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    int unsigned sel;
    checks = 0; failures = 0;
    rst = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
    m_pc = '0; m_instr = '0; m_ipc = '0; m_valid = 1'b0;
    m_halted = 1'b0; m_fault = 1'b0; m_count = '0;

    for (int i = 0; i < 256; i++) mem[i] = NOP_W;
    mem[0]    = 32'h2401_0148;
    mem[1]    = 32'h2402_0145;
    mem[2]    = 32'hAC01_0001;
    mem[8]    = 32'h0800_0010;  // 0x20: J 0x40
    mem[45]   = FAULT_W;        // 0xB4
    mem[176]  = 32'h0800_00B0;  // 0x2C0: J to itself

    // Reset then run
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_addr", imem.Address, 32'h0);
    check("rst_valid", {31'b0, InstrValid}, 32'h0);
    run(1);
    check("e1_instr", Instr, 32'h2401_0148);
    check("e1_ipc", InstrPC, 32'h0);
    run(1);
    check("e2_instr", Instr, 32'h2402_0145);
    check("e2_addr", imem.Address, 32'h8);

    // Stall at PC=8
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("stall_addr", imem.Address, 32'h8);
    check("stall_cnt", FetchCount, 32'd2);
    check("stall_ipc", InstrPC, 32'h4);
    run(1);
    check("rel_ipc", InstrPC, 32'h8);
    check("rel_instr", Instr, 32'hAC01_0001);
    check("rel_cnt", FetchCount, 32'd3);
    run(1);

    // Branch with simultaneous stall at PC=0x10
    check("pre_br_addr", imem.Address, 32'h10);
    cycle(1'b0, 1'b1, 1'b1, 32'h40);
    check("br_addr", imem.Address, 32'h40);
    check("br_valid", {31'b0, InstrValid}, 32'h0);
    run(1);
    check("br_ipc", InstrPC, 32'h40);
    check("br_valid2", {31'b0, InstrValid}, 32'h1);
    cycle(1'b0, 1'b0, 1'b1, 32'h42);
    check("mis_fault", {31'b0, Fault}, 32'h1);
    check("mis_addr", imem.Address, 32'h44);
    run(2);

    // J and self-loop halt
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h20);
    run(1);
    check("j_addr", imem.Address, 32'h40);
    check("j_instr", Instr, 32'h0800_0010);
    cycle(1'b0, 1'b0, 1'b1, 32'h2C0);
    run(1);
    check("self_ipc", InstrPC, 32'h2C0);
    check("self_halt", {31'b0, Halted}, 32'h1);
    check("self_addr", imem.Address, 32'h2C0);
    run(3);
    check("halt_valid", {31'b0, InstrValid}, 32'h0);

    // Reset mid-halt
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("mid_rst_halt", {31'b0, Halted}, 32'h0);
    check("mid_rst_cnt", FetchCount, 32'h0);
    run(1);
    check("restart_ipc", InstrPC, 32'h0);

    // Fault word at 0xB4, branch doesn't clear it, reset does
    cycle(1'b0, 1'b0, 1'b1, 32'hB4);
    run(1);
    check("fw_fault", {31'b0, Fault}, 32'h1);
    check("fw_addr", imem.Address, 32'hB4);
    run(2);
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    check("fw_br_addr", imem.Address, 32'h0);
    check("fw_br_fault", {31'b0, Fault}, 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("fw_rst", {31'b0, Fault}, 32'h0);

    // PC wrap at the top of the address space
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run(1);
    check("wrap_addr", imem.Address, 32'h0);
    check("wrap_ipc", InstrPC, 32'hFFFF_FFFC);

    // Randomized program and control traffic
    for (int i = 0; i < 256; i++) begin
      sel = $urandom_range(99);
      if (sel < 12) begin
        w = {6'b000010, 18'b0, 8'($urandom_range(255))};
      end else if (sel < 14) begin
        w = {6'b000010, 18'b0, 8'(i)};
      end else if (sel < 16) begin
        w = FAULT_W;
      end else begin
        w = $urandom;
        if (w[31:26] == 6'b000010) w[31:26] = 6'b001001;
        if (w == FAULT_W) w = NOP_W;
      end
      mem[i] = w;
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int unsigned i = 0; i < 3000; i++) begin
      logic r, st, br;
      logic [31:0] tgt;
      r  = ((m_halted || m_fault) && $urandom_range(3) == 0) || $urandom_range(99) == 0;
      st = $urandom_range(4) == 0;
      br = $urandom_range(11) == 0;
      tgt = {22'b0, 8'($urandom_range(255)), 2'b00};
      if ($urandom_range(7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      cycle(r, st, br, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
